// File: rtl/spi_master_arbiter_if.sv
// Bundle of the two requester ports and the SPI master hookup used by spi_master_arbiter.
// The master modport is the arbiter side; the slave modport is the requesters plus SPI master side.
interface spi_master_arbiter_if #(
    parameter int reg_width = 8
);
    localparam int SIZE_W = $clog2(reg_width) + 1;

    logic                 req0;
    logic                 req1;
    logic                 lock0;
    logic                 lock1;
    logic [reg_width-1:0] wdata0;
    logic [reg_width-1:0] wdata1;
    logic [SIZE_W-1:0]    size0;
    logic [SIZE_W-1:0]    size1;
    logic [reg_width-1:0] rdata0;
    logic [reg_width-1:0] rdata1;
    logic                 ack0;
    logic                 ack1;
    logic                 err0;
    logic                 err1;
    logic [1:0]           grant;
    logic                 busy;

    logic                 spi_t_start;
    logic [reg_width-1:0] spi_d_in;
    logic [SIZE_W-1:0]    spi_t_size;
    logic [reg_width-1:0] spi_d_out;
    logic                 spi_done;

    modport master (
        input  req0, req1, lock0, lock1, wdata0, wdata1, size0, size1,
        input  spi_d_out, spi_done,
        output rdata0, rdata1, ack0, ack1, err0, err1, grant, busy,
        output spi_t_start, spi_d_in, spi_t_size
    );

    modport slave (
        output req0, req1, lock0, lock1, wdata0, wdata1, size0, size1,
        output spi_d_out, spi_done,
        input  rdata0, rdata1, ack0, ack1, err0, err1, grant, busy,
        input  spi_t_start, spi_d_in, spi_t_size
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Two-requester round-robin arbiter and word sequencer in front of one SPI master,
// with a watchdog on the master's done pulse and optional bounded locked bursts.
module spi_master_arbiter #(
    parameter int reg_width      = 8,
    parameter int timeout_cycles = 1024,
    parameter int max_burst      = 4
) (
    input logic                  module_clk,
    input logic                  rst,
    spi_master_arbiter_if.master bus
);
    localparam int SIZE_W = $clog2(reg_width) + 1;
    localparam int TMR_W  = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam int BC_W   = $clog2(max_burst + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [BC_W-1:0]      burst_q, burst_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [1:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic [reg_width-1:0] din_q, din_d;
    logic [SIZE_W-1:0]    size_q, size_d;
    logic [reg_width-1:0] rdata0_q, rdata0_d;
    logic [reg_width-1:0] rdata1_q, rdata1_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 err0_q, err0_d;
    logic                 err1_q, err1_d;

    // Owner index: grant is one-hot, so bit 1 alone identifies requester 1.
    logic owner;
    assign owner = grant_q[1];

    always_ff @(posedge module_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            burst_q  <= '0;
            timer_q  <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            din_q    <= '0;
            size_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            timer_q  <= timer_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            din_q    <= din_d;
            size_q   <= size_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    logic win;
    logic own_req;
    logic own_lock;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        burst_d  = burst_q;
        timer_d  = timer_q;
        grant_d  = grant_q;
        din_d    = din_q;
        size_d   = size_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        start_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        win      = 1'b0;
        own_req  = 1'b0;
        own_lock = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester that did not own the last word wins.
                    win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    grant_d = win ? 2'b10 : 2'b01;
                    din_d   = win ? bus.wdata1 : bus.wdata0;
                    size_d  = win ? bus.size1 : bus.size0;
                    burst_d = '0;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (bus.spi_done) begin
                    if (owner) begin
                        rdata1_d = bus.spi_d_out;
                    end else begin
                        rdata0_d = bus.spi_d_out;
                    end
                    ack0_d  = ~owner;
                    ack1_d  = owner;
                    state_d = S_DONE;
                end else if (timer_q == TMR_LAST) begin
                    err0_d  = ~owner;
                    err1_d  = owner;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                last_d   = owner;
                burst_d  = burst_q + BC_W'(1);
                own_req  = owner ? bus.req1 : bus.req0;
                own_lock = owner ? bus.lock1 : bus.lock0;
                // The requester refreshes wdata/size during the ack cycle, so they are latched here.
                if (own_req && own_lock && (int'(burst_q) + 1 < max_burst)) begin
                    din_d   = owner ? bus.wdata1 : bus.wdata0;
                    size_d  = owner ? bus.size1 : bus.size0;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.spi_t_start = start_q;
    assign bus.spi_d_in    = din_q;
    assign bus.spi_t_size  = size_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.err0        = err0_q;
    assign bus.err1        = err1_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: an SPI master model answers starts, and a transaction-level
// model predicts owner order, ack/err cycles and issued words for each directed or random run.
module tb_spi_master_arbiter;
    localparam int RW = 8;
    localparam int SW = $clog2(RW) + 1;
    localparam int TO = 24;
    localparam int MB = 4;

    logic module_clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    spi_master_arbiter_if #(.reg_width(RW)) bus ();

    spi_master_arbiter #(
        .reg_width(RW),
        .timeout_cycles(TO),
        .max_burst(MB)
    ) dut (
        .module_clk(module_clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 module_clk = ~module_clk;
    initial forever begin
        @(posedge module_clk);
        cyc++;
    end
    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    bit             mdl_on = 1'b1;
    int             mdl_lat = 4;
    logic [RW-1:0]  mdl_key = '0;
    logic [RW-1:0]  mdl_cap;
    bit             mdl_abort;
    int             din_unstable = 0;
    int             mdl_last = 1;

    int             wl[2];
    logic [RW-1:0]  cur_w[2];
    logic [SW-1:0]  cur_s[2];
    logic [RW-1:0]  exp_rd[2];
    logic [RW-1:0]  sent_w0[$], sent_w1[$];
    logic [SW-1:0]  sent_s0[$], sent_s1[$];
    int             exp_own[$], exp_cyc[$], exp_err[$], exp_st[$];
    int             got_own[$], got_cyc[$], got_err[$], got_st[$];
    logic [1:0]     got_gnt[$];
    logic [RW-1:0]  got_din[$];
    logic [SW-1:0]  got_sz[$];
    int             c0;
    int             rel;

    // SPI master stand-in: done arrives mdl_lat cycles after t_start, returning d_in ^ mdl_key.
    initial begin
        bus.spi_done  = 1'b0;
        bus.spi_d_out = '0;
        forever begin
            @(negedge module_clk);
            if (mdl_on && !rst && bus.spi_t_start === 1'b1) begin
                mdl_abort = 1'b0;
                for (int i = 1; i <= mdl_lat; i++) begin
                    @(negedge module_clk);
                    if (rst) begin
                        mdl_abort = 1'b1;
                        break;
                    end
                    if (i == 1) mdl_cap = bus.spi_d_in;
                    else if (bus.spi_d_in !== mdl_cap) din_unstable++;
                end
                if (!mdl_abort) begin
                    bus.spi_d_out = mdl_cap ^ mdl_key;
                    bus.spi_done  = 1'b1;
                    @(negedge module_clk);
                    bus.spi_done  = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_grant"}, 32'(bus.grant), 0);
        check({p, "_busy"}, 32'(bus.busy), 0);
        check({p, "_start"}, 32'(bus.spi_t_start), 0);
        check({p, "_din"}, 32'(bus.spi_d_in), 0);
        check({p, "_size"}, 32'(bus.spi_t_size), 0);
        check({p, "_rdata0"}, 32'(bus.rdata0), 0);
        check({p, "_rdata1"}, 32'(bus.rdata1), 0);
        check({p, "_ackerr"}, 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 0);
    endtask

    task automatic set_word(input int r, input logic [RW-1:0] w, input logic [SW-1:0] s);
        cur_w[r] = w;
        cur_s[r] = s;
        if (r == 0) begin
            bus.wdata0 = w;
            bus.size0  = s;
            sent_w0.push_back(w);
            sent_s0.push_back(s);
        end else begin
            bus.wdata1 = w;
            bus.size1  = s;
            sent_w1.push_back(w);
            sent_s1.push_back(s);
        end
    endtask

    task automatic load(input int r);
        set_word(r, RW'($urandom_range(0, 255)), SW'($urandom_range(1, RW)));
    endtask

    // Transaction-level prediction: round-robin owner choice, bounded lock bursts,
    // ack at start+lat+1 unless the watchdog fires first at start+TO+1.
    task automatic predict(input int w0, input int w1, input bit l0, input bit l1,
                           input int lat, input bit on);
        int w[2];
        bit lk[2];
        int t, start, n, own, fin;
        exp_own.delete(); exp_cyc.delete(); exp_err.delete(); exp_st.delete();
        w[0] = w0; w[1] = w1; lk[0] = l0; lk[1] = l1;
        t = 0;
        fin = 0;
        while (w[0] > 0 || w[1] > 0) begin
            if (w[0] > 0 && w[1] > 0) own = 1 - mdl_last;
            else own = (w[1] > 0) ? 1 : 0;
            start = t + 1;
            n = 0;
            while (1) begin
                exp_st.push_back(start);
                exp_own.push_back(own);
                if (on && lat <= TO) begin
                    fin = start + lat + 1;
                    exp_err.push_back(0);
                end else begin
                    fin = start + TO + 1;
                    exp_err.push_back(1);
                end
                exp_cyc.push_back(fin);
                w[own]--;
                n++;
                if (lk[own] && w[own] > 0 && n < MB) start = fin + 1;
                else break;
            end
            mdl_last = own;
            t = fin + 1;
        end
    endtask

    task automatic resp(input int r, input logic a, input logic e,
                        input logic [RW-1:0] rd_me, input logic [RW-1:0] rd_ot);
        if (a === 1'b1 || e === 1'b1) begin
            got_own.push_back(r);
            got_cyc.push_back(rel);
            got_err.push_back((e === 1'b1) ? 1 : 0);
            check($sformatf("ack_err_excl%0d", r), 32'(a & e), 0);
            if (a === 1'b1) exp_rd[r] = cur_w[r] ^ mdl_key;
            check($sformatf("rdata%0d", r), 32'(rd_me), 32'(exp_rd[r]));
            check($sformatf("rdata%0d_hold", 1 - r), 32'(rd_ot), 32'(exp_rd[1 - r]));
            wl[r]--;
            if (wl[r] > 0) load(r);
            else if (r == 0) bus.req0 = 1'b0;
            else bus.req1 = 1'b0;
        end
    endtask

    task automatic observe(input int budget);
        int n;
        bit tmo;
        n = 0;
        tmo = 1'b0;
        c0 = cyc;
        bus.req0 = (wl[0] > 0);
        bus.req1 = (wl[1] > 0);
        while (1) begin
            @(negedge module_clk);
            n++;
            rel = cyc - c0;
            if (bus.spi_t_start === 1'b1) begin
                got_st.push_back(rel);
                got_gnt.push_back(bus.grant);
                got_din.push_back(bus.spi_d_in);
                got_sz.push_back(bus.spi_t_size);
            end
            resp(0, bus.ack0, bus.err0, bus.rdata0, bus.rdata1);
            resp(1, bus.ack1, bus.err1, bus.rdata1, bus.rdata0);
            if (wl[0] == 0 && wl[1] == 0 && bus.busy === 1'b0) break;
            if (n >= budget) begin
                tmo = 1'b1;
                break;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("observe_in_budget", 32'(tmo), 0);
    endtask

    task automatic compare(input string nm);
        int own;
        logic [RW-1:0] ew;
        logic [SW-1:0] es;
        check({nm, "_n_words"}, got_own.size(), exp_own.size());
        for (int k = 0; k < got_own.size() && k < exp_own.size(); k++) begin
            check($sformatf("%s_owner%0d", nm, k), got_own[k], exp_own[k]);
            check($sformatf("%s_resp_cyc%0d", nm, k), got_cyc[k], exp_cyc[k]);
            check($sformatf("%s_is_err%0d", nm, k), got_err[k], exp_err[k]);
        end
        check({nm, "_n_starts"}, got_st.size(), exp_st.size());
        for (int k = 0; k < got_st.size() && k < exp_st.size(); k++) begin
            own = exp_own[k];
            if (own == 0) begin
                ew = sent_w0.pop_front();
                es = sent_s0.pop_front();
            end else begin
                ew = sent_w1.pop_front();
                es = sent_s1.pop_front();
            end
            check($sformatf("%s_start_cyc%0d", nm, k), got_st[k], exp_st[k]);
            check($sformatf("%s_grant%0d", nm, k), 32'(got_gnt[k]), (own == 1) ? 2 : 1);
            check($sformatf("%s_din%0d", nm, k), 32'(got_din[k]), 32'(ew));
            check($sformatf("%s_size%0d", nm, k), 32'(got_sz[k]), 32'(es));
        end
        check({nm, "_din_stable"}, din_unstable, 0);
        check({nm, "_grant_idle"}, 32'(bus.grant), 0);
    endtask

    task automatic run(input string nm, input int w0, input int w1, input bit l0, input bit l1,
                       input int lat, input bit on, input int first0);
        sent_w0.delete(); sent_w1.delete(); sent_s0.delete(); sent_s1.delete();
        got_own.delete(); got_cyc.delete(); got_err.delete();
        got_st.delete(); got_gnt.delete(); got_din.delete(); got_sz.delete();
        mdl_lat = lat;
        mdl_on = on;
        mdl_key = RW'($urandom_range(0, 255));
        bus.lock0 = l0;
        bus.lock1 = l1;
        wl[0] = w0;
        wl[1] = w1;
        predict(w0, w1, l0, l1, lat, on);
        if (w0 > 0) begin
            if (first0 >= 0) set_word(0, RW'(first0), SW'(RW));
            else load(0);
        end
        if (w1 > 0) load(1);
        observe((w0 + w1) * (TO + 6) + 20);
        compare(nm);
        bus.lock0 = 1'b0;
        bus.lock1 = 1'b0;
        mdl_on = 1'b1;
    endtask

    initial begin
        int w0, w1, lat;
        bit l0, l1, seen;
        bus.req0 = 1'b0;   bus.req1 = 1'b0;
        bus.lock0 = 1'b0;  bus.lock1 = 1'b0;
        bus.wdata0 = '0;   bus.wdata1 = '0;
        bus.size0 = '0;    bus.size1 = '0;
        exp_rd[0] = '0;    exp_rd[1] = '0;
        wl[0] = 0;         wl[1] = 0;
        rst = 1'b1;
        repeat (3) @(negedge module_clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge module_clk);

        run("tie", 2, 2, 1'b0, 1'b0, $urandom_range(1, 15), 1'b1, -1);
        run("burst", 6, 1, 1'b1, 1'b0, $urandom_range(1, 10), 1'b1, -1);
        run("single", 1, 0, 1'b0, 1'b0, 20, 1'b1, 8'hA5);
        check("single_busy_idle", 32'(bus.busy), 0);
        run("timeout", 1, 0, 1'b0, 1'b0, 1, 1'b0, -1);
        run("after_to", 1, 0, 1'b0, 1'b0, $urandom_range(1, 15), 1'b1, -1);
        run("done_at_expiry", 0, 1, 1'b0, 1'b0, TO, 1'b1, -1);
        run("lock1_burst", 1, 5, 1'b0, 1'b1, $urandom_range(1, 6), 1'b1, -1);

        // Reset while the arbiter waits on a master that never answers.
        mdl_on = 1'b0;
        bus.wdata1 = RW'($urandom_range(0, 255));
        bus.req1 = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge module_clk);
            seen |= (bus.ack0 | bus.ack1 | bus.err0 | bus.err1);
        end
        check("midrst_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        bus.req1 = 1'b0;
        @(negedge module_clk);
        check_zero("midrst");
        rst = 1'b0;
        @(negedge module_clk);
        seen |= (bus.ack0 | bus.ack1 | bus.err0 | bus.err1);
        check("midrst_no_resp", 32'(seen), 0);
        check("midrst_idle", 32'(bus.busy), 0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        mdl_last = 1;
        mdl_on = 1'b1;
        run("post_rst_tie", 1, 1, 1'b0, 1'b0, $urandom_range(1, 15), 1'b1, -1);

        for (int it = 0; it < 5; it++) begin
            w0 = int'($urandom_range(0, 3));
            w1 = int'($urandom_range(0, 3));
            if (w0 == 0 && w1 == 0) w0 = 1;
            l0 = 1'($urandom_range(0, 1));
            l1 = 1'($urandom_range(0, 1));
            lat = int'($urandom_range(1, TO));
            run($sformatf("rnd%0d", it), w0, w1, l0, l1, lat, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
